key_cmd_queue: RTL and testbench
================================

Name: key_cmd_queue

Overview:
- Consumer end of the debounced key-press path. Accepts one-cycle press pulses from four key debouncer instances (left, right, rotate, drop).
- Encodes each press into a 2-bit command and queues it in a small FIFO.
- The Tetris game FSM reads commands through a valid/ready handshake, so no press is lost while the game logic is busy (e.g. mid-frame or mid-line-clear).

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock (same domain as the debouncers).
- rst_n  in  1  asynchronous active-low reset.
- key_left  in  1  one-cycle press pulse.
- key_right  in  1  one-cycle press pulse.
- key_rotate  in  1  one-cycle press pulse.
- key_drop  in  1  one-cycle press pulse.
- cmd_ready  in  1  consumer accepts head command this cycle.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  2  head command: 00 left, 01 right, 10 rotate, 11 drop.
- fill_level  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- clr_overflow  in  1  synchronous clear of overflow.
- overflow  out  1  sticky; a press was lost.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, read/write pointers 0, all pending flags 0.
  - cmd_valid=0, cmd_code=00, fill_level=0, overflow=0.
  - Effective immediately, including mid-operation; queued and pending presses are discarded.
- Pending flags: one per key. Request vector req = pending | key_pulse, evaluated each cycle.
- Arbiter (combinational on req): fixed priority drop > rotate > left > right. At most one enqueue per cycle.
- Enqueue allowed when fill_level<DEPTH, or when fill_level==DEPTH and a pop occurs in the same cycle.
- On a clock edge with an allowed enqueue:
  - Write the winner's code at wr_ptr and advance wr_ptr (mod DEPTH).
  - Clear the winner's pending flag.
  - Set pending for every other key whose req=1.
- On an edge with no allowed enqueue: pending <= req.
- Latency: pulse high in the cycle before edge k with an empty FIFO and no higher-priority request gives cmd_valid=1 and the matching cmd_code after edge k.
- Pop: occurs when cmd_valid && cmd_ready on an edge. Advance rd_ptr (mod DEPTH).
  - cmd_ready while empty is ignored.
  - cmd_code is the registered/array head and is stable while cmd_valid=1 and no pop occurs.
- fill_level:
  - +1 on enqueue only, -1 on pop only.
  - Unchanged when both occur, including the full+push+pop case.
- Pointer wrap: pointers are ADDR_W bits. Full/empty are derived from fill_level, never from pointer equality alone.
- Ordering: FIFO order is strict. Each key holds at most one outstanding pending press.
- overflow is set on any edge where a key pulse arrives while that key's pending flag is already 1 and that key does not win enqueue this cycle. The repeated press is coalesced and lost.
- clr_overflow clears overflow; a simultaneous set wins (overflow stays 1).
- Simultaneous pulses on all four keys, FIFO empty: enqueue order is drop, rotate, left, right over 4 consecutive edges, with no overflow.
- cmd_code when empty shows stale array contents; the consumer must qualify it with cmd_valid.

Test Plan:
- Reset then single key_rotate pulse before edge 1 -> after edge 1: cmd_valid=1, cmd_code=10, fill_level=1. Hold cmd_ready=1 one cycle -> cmd_valid=0, fill_level=0.
- All four keys pulsed in the same cycle, cmd_ready=0 -> fill_level climbs 1,2,3,4 over four edges. Pops with cmd_ready=1 then yield codes 11,10,00,01. overflow stays 0.
- Fill to 4 (DEPTH=4), pulse key_left -> left stays pending, fill_level=4. Pulse key_left again -> overflow=1. One pop -> left enqueued at the same edge, fill_level remains 4.
- Full FIFO with a pop and a new key_drop pulse in the same cycle -> fill_level stays 4, drop becomes the tail entry. Popping all entries yields correct FIFO order across pointer wrap.
- overflow=1, assert clr_overflow alone -> overflow=0 next edge. Assert clr_overflow together with a coalescing pulse -> overflow remains 1.
- FIFO holding 3 entries, pending flags set, assert rst_n=0 asynchronously mid-cycle -> outputs zero immediately. After release, no stale commands or pending presses appear.

Source files
------------

// File: rtl/key_cmd_queue_if.sv
// Command handshake between the key queue and the game FSM.
// The queue drives valid/code; the game FSM answers with ready.
interface key_cmd_queue_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_code;

   modport master (output cmd_valid, output cmd_code, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/key_cmd_queue.sv
// Collects debounced key presses, encodes them to 2-bit commands and buffers
// them in a small FIFO so the game FSM never misses a press while busy.
module key_cmd_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            key_left,
   input  logic            key_right,
   input  logic            key_rotate,
   input  logic            key_drop,
   input  logic            clr_overflow,
   output logic [ADDR_W:0] fill_level,
   output logic            overflow,
   key_cmd_queue_if.master cmd_if
);

   logic [3:0]        key_pulse;
   logic [3:0]        pending_reg;
   logic [3:0]        req;
   logic [3:0]        win;
   logic [3:0]        win_taken;
   logic [3:0]        ovf_hit;
   logic [1:0]        win_code;
   logic [1:0]        mem_reg [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   fill_reg;
   logic              ovf_reg;
   logic              full;
   logic              pop;
   logic              enq;

   // Bit index equals the command code: 0 left, 1 right, 2 rotate, 3 drop.
   assign key_pulse = {key_drop, key_rotate, key_right, key_left};
   assign req       = pending_reg | key_pulse;
   assign full      = (fill_reg == (ADDR_W + 1)'(DEPTH));
   assign pop       = cmd_if.cmd_valid && cmd_if.cmd_ready;
   assign enq       = (|req) && (!full || pop);
   assign win_taken = enq ? win : 4'b0000;

   // Fixed priority: drop > rotate > left > right.
   always_comb begin
      win      = 4'b0000;
      win_code = 2'b00;
      if (req[3]) begin
         win      = 4'b1000;
         win_code = 2'b11;
      end else if (req[2]) begin
         win      = 4'b0100;
         win_code = 2'b10;
      end else if (req[0]) begin
         win      = 4'b0001;
         win_code = 2'b00;
      end else if (req[1]) begin
         win      = 4'b0010;
         win_code = 2'b01;
      end
   end

   // A repeat press on a key that is still waiting, and not served now, is lost.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ovf
         assign ovf_hit[gi] = key_pulse[gi] & pending_reg[gi] & ~win_taken[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= 4'b0000;
      end else begin
         pending_reg <= req & ~win_taken;
      end
   end

   // Entries are reset so the head reads 00 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= 2'b00;
         end
      end else if (enq) begin
         mem_reg[wr_ptr_reg] <= win_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
         end
         if (enq && !pop) begin
            fill_reg <= fill_reg + (ADDR_W + 1)'(1);
         end else if (pop && !enq) begin
            fill_reg <= fill_reg - (ADDR_W + 1)'(1);
         end
         if (|ovf_hit) begin
            ovf_reg <= 1'b1;
         end else if (clr_overflow) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign cmd_if.cmd_valid = (fill_reg != '0);
   assign cmd_if.cmd_code  = mem_reg[rd_ptr_reg];
   assign fill_level       = fill_reg;
   assign overflow         = ovf_reg;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Self-checking bench for key_cmd_queue: per-cycle vector table with a
// command scoreboard, plus a hand-written asynchronous reset sequence.
module tb_key_cmd_queue;

   logic       clk;
   logic       rst_n;
   logic       key_left;
   logic       key_right;
   logic       key_rotate;
   logic       key_drop;
   logic       clr_overflow;
   logic [2:0] fill_level;
   logic       overflow;

   key_cmd_queue_if cmd_if ();

   key_cmd_queue #(.DEPTH(4), .ADDR_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_left     (key_left),
      .key_right    (key_right),
      .key_rotate   (key_rotate),
      .key_drop     (key_drop),
      .clr_overflow (clr_overflow),
      .fill_level   (fill_level),
      .overflow     (overflow),
      .cmd_if       (cmd_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] keys;      // bit0 left, bit1 right, bit2 rotate, bit3 drop
      logic       rdy;
      logic       clr;
      logic       enq;       // a command is expected to be queued at this edge
      logic [1:0] enq_code;
      logic       exp_valid;
      logic [1:0] exp_code;
      logic [2:0] exp_fill;
      logic       exp_ovf;
   } vec_t;

   localparam int NVEC = 28;
   vec_t       vecs [NVEC];
   logic [1:0] sb [$];
   int         checks;
   int         failures;

   function automatic vec_t mk(logic [3:0] k, logic r, logic c, logic e, logic [1:0] ec,
                               logic v, logic [1:0] cd, logic [2:0] f, logic o);
      vec_t t;
      t.keys = k; t.rdy = r; t.clr = c; t.enq = e; t.enq_code = ec;
      t.exp_valid = v; t.exp_code = cd; t.exp_fill = f; t.exp_ovf = o;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] req_val);
      checks++;
      if (act !== req_val) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, req_val);
      end
   endtask

   task automatic drive(input logic [3:0] k, input logic r, input logic c);
      key_left         = k[0];
      key_right        = k[1];
      key_rotate       = k[2];
      key_drop         = k[3];
      cmd_if.cmd_ready = r;
      clr_overflow     = c;
   endtask

   task automatic check_outputs(input string tag, input int idx, input logic v,
                                input logic [1:0] cd, input logic [2:0] f, input logic o);
      chk({tag, "_valid"}, idx, 32'(cmd_if.cmd_valid), 32'(v));
      if (v) chk({tag, "_code"}, idx, 32'(cmd_if.cmd_code), 32'(cd));
      chk({tag, "_fill"}, idx, 32'(fill_level), 32'(f));
      chk({tag, "_ovf"}, idx, 32'(overflow), 32'(o));
   endtask

   initial begin
      logic [1:0] exp_head;
      checks   = 0;
      failures = 0;

      vecs[0]  = mk(4'b0100, 0, 0, 1, 2'd2, 1, 2'd2, 3'd1, 0);
      vecs[1]  = mk(4'b0000, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0);
      vecs[2]  = mk(4'b1111, 0, 0, 1, 2'd3, 1, 2'd3, 3'd1, 0);
      vecs[3]  = mk(4'b0000, 0, 0, 1, 2'd2, 1, 2'd3, 3'd2, 0);
      vecs[4]  = mk(4'b0000, 0, 0, 1, 2'd0, 1, 2'd3, 3'd3, 0);
      vecs[5]  = mk(4'b0000, 0, 0, 1, 2'd1, 1, 2'd3, 3'd4, 0);
      vecs[6]  = mk(4'b0000, 1, 0, 0, 2'd0, 1, 2'd2, 3'd3, 0);
      vecs[7]  = mk(4'b0000, 1, 0, 0, 2'd0, 1, 2'd0, 3'd2, 0);
      vecs[8]  = mk(4'b0000, 1, 0, 0, 2'd0, 1, 2'd1, 3'd1, 0);
      vecs[9]  = mk(4'b0000, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0);
      vecs[10] = mk(4'b1000, 0, 0, 1, 2'd3, 1, 2'd3, 3'd1, 0);
      vecs[11] = mk(4'b0100, 0, 0, 1, 2'd2, 1, 2'd3, 3'd2, 0);
      vecs[12] = mk(4'b0010, 0, 0, 1, 2'd1, 1, 2'd3, 3'd3, 0);
      vecs[13] = mk(4'b1000, 0, 0, 1, 2'd3, 1, 2'd3, 3'd4, 0);
      vecs[14] = mk(4'b0001, 0, 0, 0, 2'd0, 1, 2'd3, 3'd4, 0);
      vecs[15] = mk(4'b0001, 0, 0, 0, 2'd0, 1, 2'd3, 3'd4, 1);
      vecs[16] = mk(4'b0000, 1, 0, 1, 2'd0, 1, 2'd2, 3'd4, 1);
      vecs[17] = mk(4'b1000, 1, 0, 1, 2'd3, 1, 2'd1, 3'd4, 1);
      vecs[18] = mk(4'b0000, 0, 1, 0, 2'd0, 1, 2'd1, 3'd4, 0);
      vecs[19] = mk(4'b0001, 0, 0, 0, 2'd0, 1, 2'd1, 3'd4, 0);
      vecs[20] = mk(4'b0001, 0, 1, 0, 2'd0, 1, 2'd1, 3'd4, 1);
      vecs[21] = mk(4'b0000, 1, 0, 1, 2'd0, 1, 2'd3, 3'd4, 1);
      vecs[22] = mk(4'b0000, 1, 0, 0, 2'd0, 1, 2'd0, 3'd3, 1);
      vecs[23] = mk(4'b0000, 1, 0, 0, 2'd0, 1, 2'd3, 3'd2, 1);
      vecs[24] = mk(4'b0000, 1, 0, 0, 2'd0, 1, 2'd0, 3'd1, 1);
      vecs[25] = mk(4'b0000, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 1);
      vecs[26] = mk(4'b0000, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 1);
      vecs[27] = mk(4'b0000, 0, 1, 0, 2'd0, 0, 2'd0, 3'd0, 0);

      // Power-on reset state.
      rst_n = 1'b0;
      drive(4'b0000, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", -1, 32'(cmd_if.cmd_valid), 32'd0);
      chk("rst_code",  -1, 32'(cmd_if.cmd_code),  32'd0);
      chk("rst_fill",  -1, 32'(fill_level),       32'd0);
      chk("rst_ovf",   -1, 32'(overflow),         32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].keys, vecs[i].rdy, vecs[i].clr);
         #1;
         if (vecs[i].rdy && cmd_if.cmd_valid) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", i, 32'(cmd_if.cmd_valid), 32'd0);
            end else begin
               exp_head = sb.pop_front();
               chk("sb_pop_code", i, 32'(cmd_if.cmd_code), 32'(exp_head));
            end
         end
         if (vecs[i].enq) sb.push_back(vecs[i].enq_code);
         @(posedge clk);
         #1;
         $display("vec %0d keys=%b rdy=%b clr=%b -> valid=%b code=%0d fill=%0d ovf=%b",
                  i, vecs[i].keys, vecs[i].rdy, vecs[i].clr, cmd_if.cmd_valid,
                  cmd_if.cmd_code, fill_level, overflow);
         check_outputs("vec", i, vecs[i].exp_valid, vecs[i].exp_code,
                       vecs[i].exp_fill, vecs[i].exp_ovf);
      end
      chk("sb_left", NVEC, 32'(sb.size()), 32'd0);

      // Three queued entries, a pending right press and overflow set,
      // then reset asserted between clock edges.
      @(negedge clk);
      drive(4'b1111, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_outputs("pre_rst1", 0, 1'b1, 2'd3, 3'd1, 1'b0);
      @(negedge clk);
      drive(4'b0010, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_outputs("pre_rst2", 1, 1'b1, 2'd3, 3'd2, 1'b1);
      @(negedge clk);
      drive(4'b0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_outputs("pre_rst3", 2, 1'b1, 2'd3, 3'd3, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset -> valid=%b code=%0d fill=%0d ovf=%b",
               cmd_if.cmd_valid, cmd_if.cmd_code, fill_level, overflow);
      chk("arst_valid", 0, 32'(cmd_if.cmd_valid), 32'd0);
      chk("arst_code",  0, 32'(cmd_if.cmd_code),  32'd0);
      chk("arst_fill",  0, 32'(fill_level),       32'd0);
      chk("arst_ovf",   0, 32'(overflow),         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0000, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         $display("post reset %0d -> valid=%b fill=%0d ovf=%b",
                  j, cmd_if.cmd_valid, fill_level, overflow);
         check_outputs("post_rst", j, 1'b0, 2'd0, 3'd0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
